modexp_core: RTL

- Parametrised successor to the fixed 32-bit encrypt/decrypt datapath: computes result = base^exponent mod modulus (RSA encrypt or decrypt, depending on which key is supplied).
- Replaces load/over level controls with valid/ready handshakes on both sides. Width is generic; operands wider than the modulus are reduced on entry.
- Detects a degenerate modulus, terminates early on exhausted exponent bits, and holds the result until it is consumed. Sits between the top-level controller and the I/O muxing.

---
 rtl/modexp_pkg.sv | 18 +
 rtl/mod_mul_serial.sv | 86 ++++++++
 rtl/modexp_core.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular exponentiation core.
package modexp_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StIdle,
    StReduce,
    StCheck,
    StMul,
    StSqr,
    StDone
  } state_e;

  // Value of the error output when the supplied modulus is zero.
  localparam logic ErrModZero = 1'b1;

endpackage

// File: rtl/mod_mul_serial.sv
// Serial MSB-first interleaved modular multiplier: p = a*b mod n in WordSize cycles.
module mod_mul_serial
  import modexp_pkg::*;
#(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic [WordSize-1:0] n,
  output logic                done,
  output logic [WordSize-1:0] p
);

  localparam int unsigned CntWidth = $clog2(WordSize + 1);

  logic [WordSize-1:0] a_q, a_d, b_q, b_d, n_q, n_d, p_q, p_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                run_q, run_d, done_q, done_d;

  // acc < n and bv < n keep 2*acc + bv below 3n, so two subtractions suffice.
  function automatic logic [WordSize-1:0] step(input logic [WordSize-1:0] acc,
                                               input logic                sel,
                                               input logic [WordSize-1:0] bv,
                                               input logic [WordSize-1:0] nv);
    logic [WordSize+1:0] t;
    t = {1'b0, acc, 1'b0} + (sel ? {2'b00, bv} : '0);
    if (t >= {2'b00, nv}) t = t - {2'b00, nv};
    if (t >= {2'b00, nv}) t = t - {2'b00, nv};
    return t[WordSize-1:0];
  endfunction

  // The first bit is processed on the start edge itself so a multiply spans exactly W edges.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      a_d    = a << 1;
      b_d    = b;
      n_d    = n;
      p_d    = step('0, a[WordSize-1], b, n);
      cnt_d  = CntWidth'(1);
      run_d  = (WordSize > 1);
      done_d = (WordSize == 1);
    end else if (run_q) begin
      a_d   = a_q << 1;
      p_d   = step(p_q, a_q[WordSize-1], b_q, n_q);
      cnt_d = cnt_q + CntWidth'(1);
      if (cnt_q == CntWidth'(WordSize - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = p_q;

endmodule

// File: rtl/modexp_core.sv
// Right-to-left square-and-multiply modular exponentiation with valid/ready handshakes.
module modexp_core
  import modexp_pkg::*;
#(
  parameter int unsigned WordSize = 32,
  parameter int unsigned ExpSize  = WordSize
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WordSize-1:0] in_base,
  input  logic [ExpSize-1:0]  in_exp,
  input  logic [WordSize-1:0] in_mod,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WordSize-1:0] result,
  output logic                error,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [WordSize-1:0] b_q, b_d, r_q, r_d, n_q, n_d;
  logic [ExpSize-1:0]  e_q, e_d;
  logic                err_q, err_d;

  logic                mul_start, mul_done;
  logic [WordSize-1:0] mul_a, mul_b, mul_n, mul_p;

  mod_mul_serial #(
    .WordSize(WordSize)
  ) u_mul (
    .clk  (clk),
    .reset(reset),
    .start(mul_start),
    .a    (mul_a),
    .b    (mul_b),
    .n    (mul_n),
    .done (mul_done),
    .p    (mul_p)
  );

  // A multiply is launched on the same edge the FSM enters REDUCE, MUL or SQR.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    r_d       = r_q;
    n_d       = n_q;
    e_d       = e_q;
    err_d     = err_q;
    mul_start = 1'b0;
    mul_a     = b_q;
    mul_b     = b_q;
    mul_n     = n_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          n_d   = in_mod;
          e_d   = in_exp;
          err_d = 1'b0;
          if (in_mod == '0) begin
            err_d   = ErrModZero;
            r_d     = '0;
            state_d = StDone;
          end else if (in_mod == WordSize'(1)) begin
            r_d     = '0;
            state_d = StDone;
          end else begin
            r_d       = WordSize'(1);
            mul_start = 1'b1;
            mul_a     = in_base;
            mul_b     = WordSize'(1);
            mul_n     = in_mod;
            state_d   = StReduce;
          end
        end
      end
      StReduce: begin
        if (mul_done) begin
          b_d     = mul_p;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (e_q == '0) begin
          state_d = StDone;
        end else if (e_q[0]) begin
          mul_start = 1'b1;
          mul_a     = r_q;
          state_d   = StMul;
        end else begin
          mul_start = 1'b1;
          state_d   = StSqr;
        end
      end
      StMul: begin
        if (mul_done) begin
          r_d = mul_p;
          // Skip the final squaring when no exponent bits remain.
          if ((e_q >> 1) != '0) begin
            mul_start = 1'b1;
            state_d   = StSqr;
          end else begin
            e_d     = e_q >> 1;
            state_d = StCheck;
          end
        end
      end
      StSqr: begin
        if (mul_done) begin
          b_d     = mul_p;
          e_d     = e_q >> 1;
          state_d = StCheck;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      b_q     <= '0;
      r_q     <= '0;
      n_q     <= '0;
      e_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      r_q     <= r_d;
      n_q     <= n_d;
      e_q     <= e_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = out_valid ? r_q : '0;
  assign error     = out_valid & err_q;

endmodule
